// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width: one spare bit so counting up to WIDTH-1 never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder_dataflow.sv
// One-bit dataflow full adder used as the bit slice of serial datapaths.
module full_adder_dataflow (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are loaded in parallel and summed
// LSB-first through a single full-adder slice, one bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder_dataflow u_slice (
    .x     (xr[0]),
    .y     (yr[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  if (WIDTH == 1) begin : g_sr_w1
    assign sr_next = fa_sum;
  end else begin : g_sr_wn
    assign sr_next = {fa_sum, sr[WIDTH-1:1]};
  end

  // Control FSM plus operand/result shifting; outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      xr    <= '0;
      yr    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts start just like IDLE so additions can run back-to-back.
          if (start) begin
            xr    <= x;
            yr    <= y;
            carry <= c_in;
            cnt   <= '0;
            sr    <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          xr    <= xr >> 1;
          yr    <= yr >> 1;
          sr    <= sr_next;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Publish only the complete word; partial sums never reach sum.
            sum   <= sr_next;
            c_out <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
